// File: rtl/proc_context_ctrl.sv
// rtl/proc_context_ctrl.sv - per-process context table with stall-sequenced process switching
//
// Purpose:
//   Consumer end of the memory-stage control pipeline. Holds a context table of
//   NUM_PROCS x NUM_REGS words and serves process-register reads and writes. It
//   also sequences a process switch: the request is accepted in RUN, the pipeline
//   drains for SWITCH_CYCLES cycles, and the new process id is committed.
//
// Optional feature:
//   QUANTUM_TIMER_EN - when defined, a time-slice counter raises preempt_req_out
//   after QUANTUM run cycles. When undefined, preempt_req_out is tied low.
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   exec_process_in          request a switch to proc_id_in
//   select_proc_reg_write_in write wr_data_in to ctx[proc_id_in][reg_idx_in]
//   select_proc_reg_read_in  read ctx[proc_id_in][reg_idx_in]
//   proc_id_in               target process
//   reg_idx_in               context word index
//   wr_data_in               write data
//   rd_data_out              read data, held until the next read
//   rd_valid_out             one-cycle pulse, read data valid
//   stall_out                upstream must hold its inputs stable
//   cur_pid_out              currently executing process
//   switch_done_out          one-cycle pulse, switch committed
//   preempt_req_out          time slice expired (level)

module proc_context_ctrl #(
    parameter int DATA_W        = 32,
    parameter int NUM_PROCS     = 4,
    parameter int NUM_REGS      = 16,
    parameter int SWITCH_CYCLES = 3,
    parameter int QUANTUM       = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         exec_process_in,
    input  logic                         select_proc_reg_write_in,
    input  logic                         select_proc_reg_read_in,
    input  logic [$clog2(NUM_PROCS)-1:0] proc_id_in,
    input  logic [$clog2(NUM_REGS)-1:0]  reg_idx_in,
    input  logic [DATA_W-1:0]            wr_data_in,
    output logic [DATA_W-1:0]            rd_data_out,
    output logic                         rd_valid_out,
    output logic                         stall_out,
    output logic [$clog2(NUM_PROCS)-1:0] cur_pid_out,
    output logic                         switch_done_out,
    output logic                         preempt_req_out
);

    localparam int PW    = $clog2(NUM_PROCS);
    localparam int RW    = $clog2(NUM_REGS);
    localparam int DEPTH = NUM_PROCS * NUM_REGS;
    localparam int DW    = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(SWITCH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_drain_cnt;
    logic [PW-1:0]       r_pend_pid;
    logic [PW-1:0]       r_cur_pid;
    logic                r_switch_done;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_ctx [DEPTH];

    logic                w_run;
    logic [PW+RW-1:0]    w_addr;

    assign w_run  = (r_state == S_RUN);
    assign w_addr = {proc_id_in, reg_idx_in};

    // Stall is raised in the very cycle the switch is requested so upstream
    // holds its inputs before the FSM has even left RUN.
    assign stall_out       = !w_run || exec_process_in;
    assign cur_pid_out     = r_cur_pid;
    assign switch_done_out = r_switch_done;
    assign rd_data_out     = r_rd_data;
    assign rd_valid_out    = r_rd_valid;

    // Switch sequencer. The target pid is captured on entry to DRAIN so later
    // changes of proc_id_in cannot redirect a switch already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_drain_cnt   <= '0;
            r_pend_pid    <= '0;
            r_cur_pid     <= '0;
            r_switch_done <= 1'b0;
        end else begin
            r_switch_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (exec_process_in) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= '0;
                        r_pend_pid  <= proc_id_in;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_state       <= S_RUN;
                    r_cur_pid     <= r_pend_pid;
                    r_switch_done <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    // Context table is deliberately not reset: process state survives a reset
    // of the sequencer.
    always_ff @(posedge clk) begin
        if (w_run && select_proc_reg_write_in) begin
            r_ctx[w_addr] <= wr_data_in;
        end
    end

    // The read samples the array at the same edge the write lands, so a
    // same-address read/write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_run && select_proc_reg_read_in;
            if (w_run && select_proc_reg_read_in) begin
                r_rd_data <= r_ctx[w_addr];
            end
        end
    end

`ifdef QUANTUM_TIMER_EN
    localparam int QW = $clog2(QUANTUM);
    localparam logic [QW-1:0] Q_LAST = QW'(QUANTUM - 1);

    logic [QW-1:0] r_quantum_cnt;
    logic          r_preempt;

    // Counter saturates at QUANTUM-1 and the request stays up until the next
    // switch commits, so the scheduler cannot miss it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quantum_cnt <= '0;
            r_preempt     <= 1'b0;
        end else if (r_state == S_COMMIT) begin
            r_quantum_cnt <= '0;
            r_preempt     <= 1'b0;
        end else if (w_run) begin
            if (r_quantum_cnt == Q_LAST) begin
                r_preempt <= 1'b1;
            end else begin
                r_quantum_cnt <= r_quantum_cnt + 1'b1;
            end
        end
    end

    assign preempt_req_out = r_preempt;
`else
    assign preempt_req_out = 1'b0;
`endif

endmodule
